// File: rtl/lock_pkg.sv
// ---------------------------------------------------------------------------
// lock_pkg : shared types and helpers for the logic-locking key loader
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package lock_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SHIFT  = 3'd1,
      CHECK  = 3'd2,
      COMMIT = 3'd3,
      FROZEN = 3'd4
   } lock_state_t;

   localparam int KEY_W_DEFAULT = 8;

   // Counter must reach KEY_W+1 when a parity bit trails the key.
   function automatic int cnt_width(input int key_w);
      return $clog2(key_w + 2);
   endfunction

endpackage

`default_nettype wire

// File: rtl/lock_key_loader.sv
// ---------------------------------------------------------------------------
// lock_key_loader : serial LSB-first key loader with atomic commit and lock.
// Optional even-parity frame check enabled by macro LOCK_KEY_PARITY_EN.
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lock_key_loader
   import lock_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_sdi,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic             key_lock,
   input  logic             zeroize,
   output logic [KEY_W-1:0] keyinput,
   output logic             key_loaded,
   output logic             key_err,
   output logic             busy
);

`ifdef LOCK_KEY_PARITY_EN
   localparam int FRAME_LEN = KEY_W + 1;
`else
   localparam int FRAME_LEN = KEY_W;
`endif
   localparam int                CNT_W    = cnt_width(KEY_W);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_LEN - 1);

   lock_state_t          state;
   lock_state_t          next_state;
   logic [FRAME_LEN-1:0] shadow;
   logic [CNT_W-1:0]     bit_cnt;
   logic                 accept;
   logic                 check_pass;
   logic                 lock_req;

   assign lock_req = key_lock && key_loaded;
   assign accept   = key_valid && key_ready;
   assign busy     = (state == SHIFT) || (state == CHECK) || (state == COMMIT);

`ifdef LOCK_KEY_PARITY_EN
   assign check_pass = ~(^shadow);
`else
   assign check_pass = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst || zeroize) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      key_ready  = 1'b0;
      case (state)
         IDLE: begin
            // A lock request wins over a simultaneous first bit.
            key_ready = !lock_req;
            if (lock_req) begin
               next_state = FROZEN;
            end else if (key_valid) begin
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            key_ready = 1'b1;
            if (key_valid && (bit_cnt == LAST_CNT)) begin
               next_state = CHECK;
            end
         end
         CHECK:   next_state = check_pass ? COMMIT : IDLE;
         COMMIT:  next_state = IDLE;
         FROZEN:  next_state = FROZEN;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || zeroize) begin
         shadow     <= '0;
         bit_cnt    <= '0;
         keyinput   <= '0;
         key_loaded <= 1'b0;
      end else begin
         if (accept) begin
            shadow  <= {key_sdi, shadow[FRAME_LEN-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
         if (state == CHECK) begin
            bit_cnt <= '0;
         end
         // keyinput only ever changes here, so it never shows a partial key.
         if (state == COMMIT) begin
            keyinput   <= shadow[KEY_W-1:0];
            key_loaded <= 1'b1;
         end
      end
   end

`ifdef LOCK_KEY_PARITY_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (rst || zeroize) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= 1'b0;
      end else if ((state == CHECK) && !check_pass) begin
         err_q <= 1'b1;
      end
   end

   assign key_err = err_q;
`else
   assign key_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lock_key_loader.sv
// ---------------------------------------------------------------------------
// tb_lock_key_loader : directed self-checking bench for lock_key_loader
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lock_key_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_sdi = 1'b0;
   logic       key_valid = 1'b0;
   logic       key_ready;
   logic       key_lock = 1'b0;
   logic       zeroize = 1'b0;
   logic [7:0] keyinput;
   logic       key_loaded;
   logic       key_err;
   logic       busy;

   int checks = 0;
   int errors = 0;

   lock_key_loader #(.KEY_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_sdi    (key_sdi),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_lock   (key_lock),
      .zeroize    (zeroize),
      .keyinput   (keyinput),
      .key_loaded (key_loaded),
      .key_err    (key_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] key;
      int         gap_at;
      int         gap_len;
      logic [7:0] exp_key;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      key_sdi   = b;
      key_valid = 1'b1;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
   endtask

   // Sends 8 key bits LSB first, optionally stalling after bit gap_at, then the parity bit if enabled.
   task automatic send_frame(input logic [7:0] key, input logic par, input int gap_at, input int gap_len);
      for (int i = 0; i < 8; i++) begin
         send_bit(key[i]);
         if (gap_at == i + 1) begin
            for (int g = 0; g < gap_len; g++) begin
               @(negedge clk);
               check("busy_in_gap", {31'd0, busy}, 32'd1);
            end
         end
      end
`ifdef LOCK_KEY_PARITY_EN
      send_bit(par);
`else
      if (par) key_sdi = 1'b0;
`endif
   endtask

   task automatic wait_commit();
      repeat (3) @(negedge clk);
   endtask

   vec_t vecs [4];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{key: 8'h0F, gap_at: 3, gap_len: 5, exp_key: 8'h0F};
      vecs[1] = '{key: 8'h00, gap_at: 0, gap_len: 0, exp_key: 8'h00};
      vecs[2] = '{key: 8'hC3, gap_at: 7, gap_len: 2, exp_key: 8'hC3};
      vecs[3] = '{key: 8'h3C, gap_at: 1, gap_len: 1, exp_key: 8'h3C};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_keyinput", {24'd0, keyinput}, 32'h0);
      check("rst_loaded", {31'd0, key_loaded}, 32'd0);
      check("rst_err", {31'd0, key_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, key_ready}, 32'd1);

      // Two-clock commit latency, no partial key visible
      send_frame(8'hA5, ^8'hA5, 0, 0);
      @(negedge clk);
      check("lat_c1_key", {24'd0, keyinput}, 32'h0);
      check("lat_c1_busy", {31'd0, busy}, 32'd1);
      check("lat_c1_ready", {31'd0, key_ready}, 32'd0);
      @(negedge clk);
      check("lat_c2_key", {24'd0, keyinput}, 32'h0);
      check("lat_c2_loaded", {31'd0, key_loaded}, 32'd0);
      @(negedge clk);
      check("lat_c3_key", {24'd0, keyinput}, 32'hA5);
      check("lat_c3_loaded", {31'd0, key_loaded}, 32'd1);
      check("lat_c3_busy", {31'd0, busy}, 32'd0);

      // Table-driven frames with valid gaps
      for (int v = 0; v < 4; v++) begin
         send_frame(vecs[v].key, ^vecs[v].key, vecs[v].gap_at, vecs[v].gap_len);
         wait_commit();
         check("vec_key", {24'd0, keyinput}, {24'd0, vecs[v].exp_key});
         check("vec_loaded", {31'd0, key_loaded}, 32'd1);
         check("vec_err", {31'd0, key_err}, 32'd0);
         check("vec_ready", {31'd0, key_ready}, 32'd1);
      end

`ifdef LOCK_KEY_PARITY_EN
      send_frame(8'hA5, 1'b0, 0, 0);
      wait_commit();
      check("par_ok_key", {24'd0, keyinput}, 32'hA5);
      check("par_ok_err", {31'd0, key_err}, 32'd0);
      send_frame(8'h3C, 1'b1, 0, 0);
      wait_commit();
      check("par_bad_err", {31'd0, key_err}, 32'd1);
      check("par_bad_key", {24'd0, keyinput}, 32'hA5);
      send_bit(1'b1);
      check("par_err_clear", {31'd0, key_err}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_frame(8'h3C, 1'b0, 0, 0);
      wait_commit();
`endif

      // Zeroize during COMMIT wins
      send_frame(8'h77, ^8'h77, 0, 0);
      @(negedge clk);
      @(negedge clk);
      check("zc_busy_commit", {31'd0, busy}, 32'd1);
      check("zc_prev_key", {24'd0, keyinput}, 32'h3C);
      zeroize = 1'b1;
      @(posedge clk);
      #1;
      zeroize = 1'b0;
      @(negedge clk);
      check("zc_key", {24'd0, keyinput}, 32'h0);
      check("zc_loaded", {31'd0, key_loaded}, 32'd0);
      check("zc_busy", {31'd0, busy}, 32'd0);
      check("zc_ready", {31'd0, key_ready}, 32'd1);

      // Lock freezes the committed key
      send_frame(8'h5A, ^8'h5A, 0, 0);
      wait_commit();
      check("lock_pre_key", {24'd0, keyinput}, 32'h5A);
      @(negedge clk);
      key_lock = 1'b1;
      @(posedge clk);
      #1;
      key_lock = 1'b0;
      @(negedge clk);
      check("lock_ready", {31'd0, key_ready}, 32'd0);
      send_frame(8'hFF, ^8'hFF, 0, 0);
      wait_commit();
      check("lock_key", {24'd0, keyinput}, 32'h5A);
      check("lock_ready2", {31'd0, key_ready}, 32'd0);
      check("lock_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      zeroize = 1'b1;
      @(posedge clk);
      #1;
      zeroize = 1'b0;
      @(negedge clk);
      check("unlock_key", {24'd0, keyinput}, 32'h0);
      check("unlock_ready", {31'd0, key_ready}, 32'd1);

      // Reset mid-frame discards partial bits
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      @(negedge clk);
      check("mid_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      send_frame(8'h81, ^8'h81, 0, 0);
      wait_commit();
      check("mid_rst_key", {24'd0, keyinput}, 32'h81);
      check("mid_rst_loaded", {31'd0, key_loaded}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lock_key_loader.md
LOCK_KEY_LOADER -- requirements
Module: lock_key_loader

Interface
REQ-001 The block SHALL have parameter KEY_W, default 8, meaning key width in bits (legal range 2..256).
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-004 The block SHALL have port key_sdi, input, 1 bit, meaning serial key data, LSB first.
REQ-005 The block SHALL have port key_valid, input, 1 bit, meaning key_sdi is valid this cycle.
REQ-006 The block SHALL have port key_ready, output, 1 bit, meaning the loader accepts a bit this cycle.
REQ-007 The block SHALL have port key_lock, input, 1 bit, meaning freeze the committed key until reset.
REQ-008 The block SHALL have port zeroize, input, 1 bit, meaning clear all key state immediately.
REQ-009 The block SHALL have port keyinput, output, KEY_W bits, meaning committed key driven to the locked netlist's keyinput0..keyinput(KEY_W-1).
REQ-010 The block SHALL have port key_loaded, output, 1 bit, meaning keyinput holds a committed key.
REQ-011 The block SHALL have port key_err, output, 1 bit, meaning the last frame was rejected (sticky until the next accepted bit).
REQ-012 The block SHALL have port busy, output, 1 bit, meaning a frame is in progress.

Function
REQ-013 The FSM SHALL have the states IDLE, SHIFT, CHECK, COMMIT and FROZEN.
REQ-014 Transfer rule: a bit SHALL be accepted only on a cycle with key_valid=1 and key_ready=1; key_ready=1 only in IDLE and SHIFT.
REQ-015 IDLE and SHIFT: an accepted bit SHALL shift into a shadow register from the MSB end and increment a bit counter of width clog2(KEY_W+2); the first accepted bit in IDLE SHALL move to SHIFT.
REQ-016 The transition SHIFT->CHECK SHALL occur when the frame length is reached: KEY_W bits, or KEY_W+1 with KEY_PARITY_EN.
REQ-017 CHECK SHALL take one cycle, go to COMMIT on pass and go to IDLE with key_err=1 on fail; with the feature absent, CHECK SHALL always pass.
REQ-018 COMMIT SHALL take one cycle: keyinput<=shadow and key_loaded<=1 atomically, then go to IDLE; keyinput SHALL never show a partial key.
REQ-019 Latency from the last accepted bit to the keyinput update SHALL be 2 clocks.
REQ-020 A key_valid gap mid-frame SHALL hold state indefinitely without timeout.
REQ-021 key_lock sampled in IDLE with key_loaded=1 SHALL move the FSM to FROZEN; FROZEN SHALL hold keyinput with key_ready=0 until rst or zeroize.
REQ-022 key_lock SHALL be ignored in other states and when key_loaded=0.
REQ-023 zeroize SHALL have the highest priority after rst, in any state: it clears keyinput, shadow, counter, key_loaded and key_err, sets state to IDLE, and takes effect the next clock.
REQ-024 zeroize during a COMMIT cycle SHALL win, leaving keyinput=0.
REQ-025 busy SHALL equal 1 in SHIFT, CHECK and COMMIT.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL set state=IDLE, keyinput=0, key_loaded=0, key_err=0, busy=0, counter=0 and shadow=0.
REQ-027 After reset, key_ready SHALL be 1 in the first cycle.
REQ-028 Reset mid-frame SHALL discard the partial frame.

Configuration
REQ-029 Macro LOCK_KEY_PARITY_EN defined: the frame SHALL be KEY_W key bits plus one even-parity bit, and CHECK SHALL pass iff the XOR of all KEY_W+1 bits equals 0.
REQ-030 Macro LOCK_KEY_PARITY_EN undefined: the frame SHALL be KEY_W bits, no parity storage SHALL exist, and key_err SHALL be constant 0.

Structure
REQ-031 A shared package lock_pkg SHALL hold the FSM state enum type, the default key width constant and the counter-width function.
REQ-032 The FSM and datapath SHALL reside in one module, with no sub-module.
REQ-033 The parity reduction SHALL be inline under the macro.

Verification
REQ-034 Scenario: KEY_W=8, shift 0xA5 LSB first with continuous valid -> keyinput=0xA5 and key_loaded=1 exactly 2 clocks after the 8th bit; keyinput stays 0 before that.
REQ-035 Scenario: with the macro defined, send 0xA5 with parity 0 -> commit; send 0x3C with parity 1 -> key_err=1 and keyinput stays 0xA5.
REQ-036 Scenario: insert 5 idle cycles after bit 3 of 0x0F -> result keyinput=0x0F and busy=1 throughout the gap.
REQ-037 Scenario: commit 0x5A, assert key_lock, then shift 0xFF -> key_ready=0 and keyinput remains 0x5A.
REQ-038 Scenario: assert zeroize during COMMIT of 0x77 -> next cycle keyinput=0, key_loaded=0 and state IDLE.
REQ-039 Scenario: assert rst after bit 5 of a frame, then send 0x81 -> keyinput=0x81, with no leftover bits.
